// File: rtl/x37_bcd_display_pkg.sv
// Shared definitions for the x37 BCD display stage: FSM state encoding,
// seven-segment patterns ({g,f,e,d,c,b,a}, active-high) and datapath widths.
package x37_bcd_display_pkg;

  localparam int unsigned PROD_W = 11;          // binary product width
  localparam int unsigned DIGITS = 4;           // BCD digits produced
  localparam int unsigned SHIFTS = 11;          // double-dabble shift steps
  localparam int unsigned BCD_W  = 4 * DIGITS;  // packed BCD width
  localparam int unsigned CNT_W  = 4;           // shift counter width
  localparam int unsigned SEG_W  = 7;           // segment pattern width

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/x37_bcd_display_if.sv
// Product-in / display-out bundle of the x37 BCD display stage.
//   in_valid, in_prod : upstream product handshake (master drives)
//   in_ready          : stage idle, product can be accepted
//   out_valid         : one-cycle pulse when bcd/segments update
//   bcd               : {thousands, hundreds, tens, ones}
//   seg3..seg0        : registered seven-segment patterns, seg3 = thousands
interface x37_bcd_display_if;
  import x37_bcd_display_pkg::*;

  logic              in_valid;
  logic [PROD_W-1:0] in_prod;
  logic              in_ready;
  logic              out_valid;
  logic [BCD_W-1:0]  bcd;
  logic [SEG_W-1:0]  seg3;
  logic [SEG_W-1:0]  seg2;
  logic [SEG_W-1:0]  seg1;
  logic [SEG_W-1:0]  seg0;

  modport master (
    output in_valid, in_prod,
    input  in_ready, out_valid, bcd, seg3, seg2, seg1, seg0
  );

  modport slave (
    input  in_valid, in_prod,
    output in_ready, out_valid, bcd, seg3, seg2, seg1, seg0
  );

endinterface

// File: rtl/x37_bcd_display_seg7_decode.sv
// Combinational BCD digit to seven-segment decoder.
//   digit : 4-bit BCD digit (0-9; anything else shows blank)
//   seg   : pattern {g,f,e,d,c,b,a}, active-high
module x37_bcd_display_seg7_decode
  import x37_bcd_display_pkg::*;
(
  input  logic [3:0]       digit,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/x37_bcd_display.sv
// Sequential binary-to-BCD converter and seven-segment driver for the x37
// multiplier product. A product accepted on the handshake is converted by an
// 11-step shift-and-add-3 engine; the final step loads the registered BCD and
// segment outputs and pulses out_valid for one cycle.
//   clk, rst      : clock, asynchronous active-high reset
//   bus (slave)   : in_valid/in_prod/in_ready handshake, out_valid, bcd,
//                   seg3..seg0
//   BLANK_LEADING : 1 = leading zero digits above ones are driven blank
module x37_bcd_display
  import x37_bcd_display_pkg::*;
#(
  parameter bit BLANK_LEADING = 1'b1
)
(
  input  logic             clk,
  input  logic             rst,
  x37_bcd_display_if.slave bus
);

  localparam int unsigned SR_W = BCD_W + PROD_W;

  state_t                        state;
  state_t                        state_nx;
  logic [CNT_W-1:0]              cnt;
  logic [SR_W-1:0]               sr;
  logic [SR_W-1:0]               sr_fix;
  logic [SR_W-1:0]               sr_nx;
  logic                          last_shift;
  logic [DIGITS-1:0][3:0]        dig;
  logic [DIGITS-1:0][SEG_W-1:0]  seg_raw;
  logic [DIGITS-1:0][SEG_W-1:0]  seg_bl;
  logic [DIGITS-1:0][SEG_W-1:0]  seg_q;

  assign last_shift = (state == SHIFT) && (cnt == CNT_W'(SHIFTS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    bus.in_ready = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = SHIFT;
      end
      SHIFT: begin
        if (last_shift) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Add-3 correction on every BCD nibble, then shift the whole register.
  always_comb begin
    sr_fix = sr;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (sr_fix[PROD_W + 4*i +: 4] >= 4'd5)
        sr_fix[PROD_W + 4*i +: 4] = sr_fix[PROD_W + 4*i +: 4] + 4'd3;
    end
    sr_nx = {sr_fix[SR_W-2:0], 1'b0};
  end

  // Decode from the post-shift value so the final edge can load segments
  // together with bcd.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    assign dig[g] = sr_nx[PROD_W + 4*g +: 4];
    x37_bcd_display_seg7_decode u_seg7_decode (
      .digit (dig[g]),
      .seg   (seg_raw[g])
    );
  end

  always_comb begin
    seg_bl    = seg_raw;
    if (BLANK_LEADING) begin
      if (dig[3] == 4'd0)
        seg_bl[3] = SEG_BLANK;
      if (dig[3] == 4'd0 && dig[2] == 4'd0)
        seg_bl[2] = SEG_BLANK;
      if (dig[3] == 4'd0 && dig[2] == 4'd0 && dig[1] == 4'd0)
        seg_bl[1] = SEG_BLANK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr            <= '0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.bcd       <= '0;
      seg_q         <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sr  <= {{BCD_W{1'b0}}, bus.in_prod};
            cnt <= '0;
          end
        end
        SHIFT: begin
          sr  <= sr_nx;
          cnt <= cnt + CNT_W'(1);
          if (last_shift) begin
            bus.bcd       <= sr_nx[SR_W-1 -: BCD_W];
            seg_q         <= seg_bl;
            bus.out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.seg3 = seg_q[3];
  assign bus.seg2 = seg_q[2];
  assign bus.seg1 = seg_q[1];
  assign bus.seg0 = seg_q[0];

endmodule

// File: tb/tb_x37_bcd_display.sv
// Self-checking bench for x37_bcd_display: two instances (blanking on/off)
// share stimulus; a decimal-arithmetic model predicts every output each cycle.
module tb_x37_bcd_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [10:0] in_prod;
  bit          chk_en;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  x37_bcd_display_if bus_b ();
  x37_bcd_display_if bus_n ();

  assign bus_b.in_valid = in_valid;
  assign bus_b.in_prod  = in_prod;
  assign bus_n.in_valid = in_valid;
  assign bus_n.in_prod  = in_prod;

  x37_bcd_display #(.BLANK_LEADING(1'b1)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  x37_bcd_display #(.BLANK_LEADING(1'b0)) u_dut_n (.clk(clk), .rst(rst), .bus(bus_n));

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [27:0] to_segs(input int v, input bit blank);
    logic [6:0] s3, s2, s1, s0;
    s3 = (blank && v < 1000) ? 7'h00 : seg_tab[v / 1000];
    s2 = (blank && v < 100)  ? 7'h00 : seg_tab[(v / 100) % 10];
    s1 = (blank && v < 10)   ? 7'h00 : seg_tab[(v / 10) % 10];
    s0 = seg_tab[v % 10];
    return {s3, s2, s1, s0};
  endfunction

  int          rem;        // cycles until the in-flight product completes
  int          pend;
  bit          m_ov;
  logic [15:0] m_bcd;
  logic [27:0] m_seg_b, m_seg_n;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem = 0; m_ov = 0; m_bcd = '0; m_seg_b = '0; m_seg_n = '0;
    end else begin
      m_ov = 0;
      if (rem == 0) begin
        if (in_valid === 1'b1) begin
          pend = int'(in_prod);
          rem  = 11;
        end
      end else begin
        rem--;
        if (rem == 0) begin
          m_ov    = 1;
          m_bcd   = to_bcd(pend);
          m_seg_b = to_segs(pend, 1'b1);
          m_seg_n = to_segs(pend, 1'b0);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] segs_of_b();
    return {bus_b.seg3, bus_b.seg2, bus_b.seg1, bus_b.seg0};
  endfunction

  function automatic logic [27:0] segs_of_n();
    return {bus_n.seg3, bus_n.seg2, bus_n.seg1, bus_n.seg0};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready_b", 32'(bus_b.in_ready), 32'(rem == 0));
      chk("ready_n", 32'(bus_n.in_ready), 32'(rem == 0));
      chk("ovalid_b", 32'(bus_b.out_valid), 32'(m_ov));
      chk("ovalid_n", 32'(bus_n.out_valid), 32'(m_ov));
      chk("bcd_b", 32'(bus_b.bcd), 32'(m_bcd));
      chk("bcd_n", 32'(bus_n.bcd), 32'(m_bcd));
      chk("seg_b", 32'(segs_of_b()), 32'(m_seg_b));
      chk("seg_n", 32'(segs_of_n()), 32'(m_seg_n));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_one(input int v, input logic [15:0] eb,
                         input logic [27:0] esb, input logic [27:0] esn);
    int k;
    bit found;
    @(posedge clk); #2;
    in_valid = 1'b1;
    in_prod  = 11'(v);
    @(posedge clk); #2;   // acceptance edge just passed
    in_valid = 1'b0;
    k = 0; found = 0;
    while (k < 20 && !found) begin
      @(negedge clk);
      k++;
      if (bus_b.out_valid === 1'b1) found = 1;
    end
    chk($sformatf("latency_%0d", v), 32'(k), 32'd12);
    chk($sformatf("bcd_lit_%0d", v), 32'(bus_b.bcd), 32'(eb));
    chk($sformatf("segb_lit_%0d", v), 32'(segs_of_b()), 32'(esb));
    chk($sformatf("segn_lit_%0d", v), 32'(segs_of_n()), 32'(esn));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(bus_b.in_ready & bus_n.in_ready), 32'd1);
    chk({tag, "_ovalid"}, 32'(bus_b.out_valid | bus_n.out_valid), 32'd0);
    chk({tag, "_bcd"}, 32'(bus_b.bcd | bus_n.bcd), 32'd0);
    chk({tag, "_seg"}, 32'(segs_of_b() | segs_of_n()), 32'd0);
  endtask

  initial begin
    int k, k1, k2;
    bit f1, f2;
    chk_en   = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_prod  = '0;
    #1 rst = 1'b1;
    #1 chk_reset_vals("reset");
    chk_en = 1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    run_one(1147, 16'h1147, {7'h06, 7'h06, 7'h66, 7'h07}, {7'h06, 7'h06, 7'h66, 7'h07});
    run_one(37,   16'h0037, {7'h00, 7'h00, 7'h4F, 7'h07}, {7'h3F, 7'h3F, 7'h4F, 7'h07});
    run_one(0,    16'h0000, {7'h00, 7'h00, 7'h00, 7'h3F}, {7'h3F, 7'h3F, 7'h3F, 7'h3F});
    run_one(2047, 16'h2047, {7'h5B, 7'h3F, 7'h66, 7'h07}, {7'h5B, 7'h3F, 7'h66, 7'h07});

    // Back-to-back: in_valid held across two products.
    @(posedge clk); #2;
    in_valid = 1'b1;
    in_prod  = 11'd185;
    @(posedge clk); #2;
    in_prod  = 11'd0;
    k = 0; f1 = 0; f2 = 0; k1 = 0; k2 = 0;
    while (k < 40 && !f1) begin
      @(negedge clk); k++;
      if (bus_b.out_valid === 1'b1) begin f1 = 1; k1 = k; end
    end
    chk("b2b_first_lat", 32'(k1), 32'd12);
    chk("b2b_first_bcd", 32'(bus_b.bcd), 32'h0185);
    chk("b2b_first_segb", 32'(segs_of_b()), 32'({7'h00, 7'h06, 7'h7F, 7'h6D}));
    chk("b2b_first_segn", 32'(segs_of_n()), 32'({7'h3F, 7'h06, 7'h7F, 7'h6D}));
    @(posedge clk); #2;
    in_valid = 1'b0;
    while (k < 60 && !f2) begin
      @(negedge clk); k++;
      if (bus_b.out_valid === 1'b1) begin f2 = 1; k2 = k; end
    end
    chk("b2b_spacing", 32'(k2 - k1), 32'd12);
    chk("b2b_second_bcd", 32'(bus_b.bcd), 32'h0000);

    // Reset during the fifth shift aborts the conversion.
    @(posedge clk); #2;
    in_valid = 1'b1;
    in_prod  = 11'd1147;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_reset_vals("abort");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    run_one(74, 16'h0074, {7'h00, 7'h00, 7'h07, 7'h66}, {7'h3F, 7'h3F, 7'h07, 7'h66});

    // Randomized traffic with occasional resets.
    repeat (900) begin
      @(posedge clk); #2;
      in_valid = ($urandom_range(0, 2) != 0);
      in_prod  = 11'($urandom);
      rst      = ($urandom_range(0, 149) == 0);
    end
    @(posedge clk); #2;
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
